// File: rtl/async_sram_target_pkg.sv
// Shared constants and FSM encoding for the async SRAM responder.
// ASYNC_SRAM_TARGET_GLITCH_FILTER_EN deepens the A/DQ delay by one flop to track the control filter.
package async_sram_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

`ifdef ASYNC_SRAM_TARGET_GLITCH_FILTER_EN
    localparam int DATA_DLY = SYNC_STAGES + 2;
`else
    localparam int DATA_DLY = SYNC_STAGES + 1;
`endif

endpackage

// File: rtl/async_sram_target_sync.sv
// Multi-bit flop-chain synchroniser with a parameterised reset value.
// Latency: SYNC_STAGES cycles. No backpressure.
// Each bit is treated independently; only use it for quasi-static strobes.
module async_sram_target_sync
    import async_sram_target_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= RST_VAL;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/async_sram_target.sv
// Async 16-bit SRAM responder: syncs host strobes, turns them into valid/ready bus reads/writes.
// Latency: strobe to bus_req 3 cycles, read data on DQ 4+N (one more each with ASYNC_SRAM_TARGET_GLITCH_FILTER_EN).
// Backpressure: bus_req held stable until bus_ready; one pending write slot, further writes set err_overrun.
module async_sram_target
    import async_sram_target_pkg::*;
#(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRAM_A-1:0]  padin_sram_a,
    input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
    input  logic                 padin_sram_cs_n,
    input  logic                 padin_sram_oe_n,
    input  logic                 padin_sram_we_n,
    input  logic                 padin_sram_ub_n,
    input  logic                 padin_sram_lb_n,
    output logic [N_SRAM_DQ-1:0] padout_sram_dq,
    output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
    output logic                 bus_req,
    input  logic                 bus_ready,
    output logic                 bus_write,
    output logic [N_SRAM_A-1:0]  bus_addr,
    output logic [1:0]           bus_be,
    output logic [N_SRAM_DQ-1:0] bus_wdata,
    input  logic [N_SRAM_DQ-1:0] bus_rdata,
    input  logic                 err_clr,
    output logic                 err_overrun
);

    localparam int N_AD = N_SRAM_A + N_SRAM_DQ;

    // Control vector order: {cs_n, oe_n, we_n, ub_n, lb_n}
    logic [4:0] ctl_n_s, ctl_n;

    async_sram_target_sync #(.WIDTH(5), .RST_VAL(5'h1f)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({padin_sram_cs_n, padin_sram_oe_n, padin_sram_we_n, padin_sram_ub_n, padin_sram_lb_n}),
        .q   (ctl_n_s)
    );

`ifdef ASYNC_SRAM_TARGET_GLITCH_FILTER_EN
    logic [4:0] ctl_n_prev, ctl_n_hold, ctl_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_n_prev <= '1;
            ctl_n_hold <= '1;
        end else begin
            ctl_n_prev <= ctl_n_s;
            ctl_n_hold <= ctl_n;
        end
    end

    // A bit only moves once two consecutive synced samples agree.
    assign ctl_diff = ctl_n_s ^ ctl_n_prev;
    assign ctl_n    = (ctl_n_s & ~ctl_diff) | (ctl_n_hold & ctl_diff);
`else
    assign ctl_n = ctl_n_s;
`endif

    logic       cs, oe, we, cs_q, we_q, rd_act, wr_end;
    logic [1:0] be_now, be_q;

    assign cs     = ~ctl_n[4];
    assign oe     = ~ctl_n[3];
    assign we     = ~ctl_n[2];
    assign be_now = {~ctl_n[1], ~ctl_n[0]};
    assign rd_act = cs & oe & ~we;
    assign wr_end = cs_q & we_q & (~we | ~cs);

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= 1'b0;
            we_q <= 1'b0;
            be_q <= 2'b00;
        end else begin
            cs_q <= cs;
            we_q <= we;
            be_q <= be_now;
        end
    end

    // A/DQ delay line: the last stage matches the previous cycle's accepted control.
    logic [N_AD-1:0]      dly [DATA_DLY];
    logic [N_SRAM_A-1:0]  al_addr;
    logic [N_SRAM_DQ-1:0] al_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DATA_DLY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {padin_sram_a, padin_sram_dq};
            for (int i = 1; i < DATA_DLY; i++) dly[i] <= dly[i-1];
        end
    end

    assign al_addr = dly[DATA_DLY-1][N_AD-1:N_SRAM_DQ];
    assign al_data = dly[DATA_DLY-1][N_SRAM_DQ-1:0];

    state_t               state, state_nxt;
    logic                 ld_wr, ld_rd, rd_done, xfer;
    logic                 slot_full, wr_take;
    logic [N_SRAM_A-1:0]  slot_addr, rd_addr;
    logic [N_SRAM_DQ-1:0] slot_data;
    logic [1:0]           slot_be;
    logic                 padoe_r;

    assign xfer = bus_req & bus_ready;

    always_comb begin
        state_nxt = state;
        ld_wr     = 1'b0;
        ld_rd     = 1'b0;
        rd_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slot_full) begin
                    state_nxt = ST_WRITE;
                    ld_wr     = 1'b1;
                end else if (rd_act) begin
                    state_nxt = ST_READ;
                    ld_rd     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (xfer) state_nxt = ST_IDLE;
            end
            ST_READ: begin
                if (xfer) begin
                    state_nxt = ST_HOLD;
                    rd_done   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!rd_act) begin
                    state_nxt = ST_IDLE;
                end else if (al_addr != rd_addr) begin
                    state_nxt = ST_READ;
                    ld_rd     = 1'b1;
                end else if (slot_full) begin
                    state_nxt = ST_WRITE;
                    ld_wr     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The slot is released as soon as its contents move onto the bus, so one
    // write can be in flight while the next one waits.
    assign wr_take = wr_end & (~slot_full | ld_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full   <= 1'b0;
            slot_addr   <= '0;
            slot_data   <= '0;
            slot_be     <= 2'b00;
            err_overrun <= 1'b0;
        end else begin
            if (wr_take) begin
                slot_full <= 1'b1;
                slot_addr <= al_addr;
                slot_data <= al_data;
                slot_be   <= be_q;
            end else if (ld_wr) begin
                slot_full <= 1'b0;
            end
            if (wr_end && !wr_take) err_overrun <= 1'b1;
            else if (err_clr)       err_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus_req        <= 1'b0;
            bus_write      <= 1'b0;
            bus_addr       <= '0;
            bus_be         <= 2'b00;
            bus_wdata      <= '0;
            rd_addr        <= '0;
            padout_sram_dq <= '0;
            padoe_r        <= 1'b0;
        end else begin
            state   <= state_nxt;
            padoe_r <= rd_act;
            if (ld_wr) begin
                bus_req   <= 1'b1;
                bus_write <= 1'b1;
                bus_addr  <= slot_addr;
                bus_be    <= slot_be;
                bus_wdata <= slot_data;
            end else if (ld_rd) begin
                bus_req   <= 1'b1;
                bus_write <= 1'b0;
                bus_addr  <= al_addr;
                bus_be    <= be_now;
                rd_addr   <= al_addr;
            end else if (xfer) begin
                bus_req <= 1'b0;
            end
            if (rd_done) padout_sram_dq <= bus_rdata;
        end
    end

    assign padoe_sram_dq = {N_SRAM_DQ{padoe_r}};

endmodule

// File: tb/tb_async_sram_target.sv
// Directed bench for async_sram_target: host pad stimulus, bus responder with scoreboard of expected transfers.
module tb_async_sram_target;

`ifdef ASYNC_SRAM_TARGET_GLITCH_FILTER_EN
    localparam int F = 1;
`else
    localparam int F = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_a = '0;
    logic [15:0] sram_dq = '0;
    logic        cs_n = 1'b1, oe_n = 1'b1, we_n = 1'b1, ub_n = 1'b1, lb_n = 1'b1;
    logic [15:0] padout_dq, padoe_dq;
    logic        bus_req, bus_write, err_overrun;
    logic        bus_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [17:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    async_sram_target #(.N_SRAM_A(18), .N_SRAM_DQ(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .padin_sram_a    (sram_a),
        .padin_sram_dq   (sram_dq),
        .padin_sram_cs_n (cs_n),
        .padin_sram_oe_n (oe_n),
        .padin_sram_we_n (we_n),
        .padin_sram_ub_n (ub_n),
        .padin_sram_lb_n (lb_n),
        .padout_sram_dq  (padout_dq),
        .padoe_sram_dq   (padoe_dq),
        .bus_req         (bus_req),
        .bus_ready       (bus_ready),
        .bus_write       (bus_write),
        .bus_addr        (bus_addr),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .err_clr         (err_clr),
        .err_overrun     (err_overrun)
    );

    // Fabric memory image seen by reads
    always_comb begin
        case (bus_addr)
            18'h00010: bus_rdata = 16'hA5A5;
            18'h00011: bus_rdata = 16'h5A3C;
            default:   bus_rdata = 16'hDEAD;
        endcase
    end

    typedef struct {
        logic        wr;
        logic [17:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } xact_t;

    xact_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    wait_cfg = 0;
    bit    hold_off = 1'b0;
    int    wcnt = 0;
    int    n_xact = 0;

    // Bus responder and monitor: grants after wait_cfg cycles, checks each transfer it grants.
    always @(negedge clk) begin
        if (bus_ready) begin
            bus_ready = 1'b0;
            wcnt = 0;
        end else if (!bus_req || hold_off) begin
            wcnt = 0;
        end else if (wcnt >= wait_cfg) begin
            bus_ready = 1'b1;
            n_cmp++;
            n_xact++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL xact%0d unexpected: got wr=%0b addr=%h be=%b wdata=%h, expected none",
                         n_xact, bus_write, bus_addr, bus_be, bus_wdata);
            end else begin
                xact_t e;
                e = exp_q.pop_front();
                if (bus_write !== e.wr || bus_addr !== e.addr || bus_be !== e.be ||
                    (e.wr && bus_wdata !== e.wdata)) begin
                    n_err++;
                    $display("FAIL xact%0d: got wr=%0b addr=%h be=%b wdata=%h, expected wr=%0b addr=%h be=%b wdata=%h",
                             n_xact, bus_write, bus_addr, bus_be, bus_wdata, e.wr, e.addr, e.be, e.wdata);
                end
            end
        end else begin
            wcnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_xact(input logic wr, input logic [17:0] a, input logic [1:0] be, input logic [15:0] d);
        xact_t x;
        x.wr = wr; x.addr = a; x.be = be; x.wdata = d;
        exp_q.push_back(x);
    endtask

    task automatic host_write(input logic [17:0] a, input logic [15:0] d,
                              input logic u_n, input logic l_n, input int low);
        sram_a = a; sram_dq = d; ub_n = u_n; lb_n = l_n; cs_n = 1'b0;
        cyc(1);
        we_n = 1'b0;
        cyc(low);
        we_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        cyc(3);
        chk("rst_padoe", {16'h0, padoe_dq}, 32'h0);
        chk("rst_padout", {16'h0, padout_dq}, 32'h0);
        chk("rst_req_wr_be", {28'h0, bus_req, bus_write, bus_be}, 32'h0);
        chk("rst_addr", {14'h0, bus_addr}, 32'h0);
        chk("rst_wdata", {16'h0, bus_wdata}, 32'h0);
        chk("rst_err", {31'h0, err_overrun}, 32'h0);
        rst = 1'b0;
        cyc(2);

        // Plain writes, full and lower-byte-only
        expect_xact(1'b1, 18'h12345, 2'b11, 16'hBEEF);
        host_write(18'h12345, 16'hBEEF, 1'b0, 1'b0, 4);
        expect_xact(1'b1, 18'h00ABC, 2'b01, 16'h1234);
        host_write(18'h00ABC, 16'h1234, 1'b1, 1'b0, 4);
        cyc(8);
        chk("wr_err", {31'h0, err_overrun}, 32'h0);
        chk("wr_idle_req", {31'h0, bus_req}, 32'h0);

        // Read with 3 bus wait cycles
        sram_a = 18'h00010; cs_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        cyc(4);
        wait_cfg = 3;
        expect_xact(1'b0, 18'h00010, 2'b11, 16'h0);
        oe_n = 1'b0;
        cyc(2 + F);
        chk("rd_oe_early", {16'h0, padoe_dq}, 32'h0);
        cyc(1);
        chk("rd_oe_on", {16'h0, padoe_dq}, 32'hFFFF);
        cyc(3);
        chk("rd_dq_early", {16'h0, padout_dq}, 32'h0);
        cyc(1);
        chk("rd_dq", {16'h0, padout_dq}, 32'hA5A5);

        // Page read: address change while OE held
        wait_cfg = 0;
        expect_xact(1'b0, 18'h00011, 2'b11, 16'h0);
        sram_a = 18'h00011;
        cyc(4 + F);
        chk("page_dq_old", {16'h0, padout_dq}, 32'hA5A5);
        cyc(1);
        chk("page_dq_new", {16'h0, padout_dq}, 32'h5A3C);
        chk("page_oe", {16'h0, padoe_dq}, 32'hFFFF);

        // Read release
        oe_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        cyc(2 + F);
        chk("rel_oe_hold", {16'h0, padoe_dq}, 32'hFFFF);
        cyc(1);
        chk("rel_oe_off", {16'h0, padoe_dq}, 32'h0);
        cyc(3);

        // Overrun: bus stalled, third write dropped
        hold_off = 1'b1;
        expect_xact(1'b1, 18'h00100, 2'b11, 16'h1111);
        expect_xact(1'b1, 18'h00200, 2'b11, 16'h2222);
        host_write(18'h00100, 16'h1111, 1'b0, 1'b0, 4);
        host_write(18'h00200, 16'h2222, 1'b0, 1'b0, 4);
        host_write(18'h00300, 16'h3333, 1'b0, 1'b0, 4);
        cyc(4);
        chk("ovr_err_set", {31'h0, err_overrun}, 32'h1);
        chk("ovr_stuck", {13'h0, bus_req, bus_addr}, {13'h0, 1'b1, 18'h00100});
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("ovr_err_clr", {31'h0, err_overrun}, 32'h0);
        hold_off = 1'b0;
        cyc(15);
        chk("ovr_drain", exp_q.size(), 32'h0);

        // Reset while a read is stalled on the bus
        hold_off = 1'b1;
        sram_a = 18'h00020; cs_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
        cyc(4);
        oe_n = 1'b0;
        cyc(5 + F);
        chk("mid_req", {31'h0, bus_req}, 32'h1);
        rst = 1'b1; oe_n = 1'b1; cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        cyc(1);
        chk("mid_rst_req", {31'h0, bus_req}, 32'h0);
        chk("mid_rst_oe", {16'h0, padoe_dq}, 32'h0);
        cyc(2);
        rst = 1'b0;
        hold_off = 1'b0;
        cyc(3);

        // One-cycle WE_n pulse: accepted without the filter, rejected with it
        sram_a = 18'h00777; sram_dq = 16'h7777; cs_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
`ifndef ASYNC_SRAM_TARGET_GLITCH_FILTER_EN
        expect_xact(1'b1, 18'h00777, 2'b11, 16'h7777);
`endif
        cyc(3);
        we_n = 1'b0;
        cyc(1);
        we_n = 1'b1;
        cyc(2);
        cs_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        cyc(10);
        chk("final_drain", exp_q.size(), 32'h0);
        chk("final_xacts", n_xact, (F != 0) ? 32'd6 : 32'd7);
        chk("final_err", {31'h0, err_overrun}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
